// File: rtl/uart_rx_if.sv
// uart_rx_if: receiver-side signal bundle between the serial line/baud tick and the APB register block.
// Members:
//   os_tick    - one-clk pulse at 16x baud
//   rx_enable  - receiver enable, low forces IDLE
//   cfg_reg    - [1:0] length-5, [2] two stop bits, [3] parity enable, [4] odd parity
//   rx         - asynchronous serial input, idle high
//   rx_data    - last received data, right-justified
//   rx_valid   - one-clk pulse when rx_data/parity_err/frame_err update
//   rx_busy    - frame in progress
//   parity_err - parity mismatch on last frame
//   frame_err  - a stop bit sampled 0 on last frame
// slave modport is the receiver; master modport is whoever drives the line and reads the results.
interface uart_rx_if;
    logic       os_tick;
    logic       rx_enable;
    logic [4:0] cfg_reg;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       parity_err;
    logic       frame_err;
    modport slave (
        input  os_tick, rx_enable, cfg_reg, rx,
        output rx_data, rx_valid, rx_busy, parity_err, frame_err
    );
    modport master (
        output os_tick, rx_enable, cfg_reg, rx,
        input  rx_data, rx_valid, rx_busy, parity_err, frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver, 5-8 data bits, optional parity, 1 or 2 stop bits.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - uart_rx_if.slave (tick, enable, config and line in; data, valid, busy, errors out)
// Optional build macro: UART_RX_MAJORITY_EN selects a 2-of-3 majority vote on the three
// ticks ending at each decision tick instead of a single sample on the decision tick.
module uart_rx (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t     r_state;
    logic       r_rx_meta, r_rx_s;
    logic [3:0] r_cnt;
    logic [4:0] r_cfg;
    logic [7:0] r_shift;
    logic [2:0] r_idx;
    logic       r_stop2, r_par_flag, r_frame_flag;
    logic [7:0] r_data;
    logic       r_valid, r_busy, r_perr, r_ferr;
    logic       w_bit, w_decide;
    logic [2:0] w_len_m1;
    // Start bit is judged at its middle (cnt 7); every later bit one full bit time on (cnt 15).
    assign w_decide = bus.os_tick && (r_state == START ? r_cnt == 4'd7 : r_cnt == 4'd15);
    assign w_len_m1 = {1'b1, r_cfg[1:0]};
`ifdef UART_RX_MAJORITY_EN
    logic r_s_a, r_s_b;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_a <= 1'b1;
            r_s_b <= 1'b1;
        end else if (bus.os_tick) begin
            if (r_cnt == (r_state == START ? 4'd5 : 4'd13)) r_s_a <= r_rx_s;
            if (r_cnt == (r_state == START ? 4'd6 : 4'd14)) r_s_b <= r_rx_s;
        end
    end
    // Third vote is the live synchronized sample on the decision tick itself.
    assign w_bit = (r_s_a & r_s_b) | (r_s_a & r_rx_s) | (r_s_b & r_rx_s);
`else
    assign w_bit = r_rx_s;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_cfg        <= 5'd0;
            r_shift      <= 8'd0;
            r_idx        <= 3'd0;
            r_stop2      <= 1'b0;
            r_par_flag   <= 1'b0;
            r_frame_flag <= 1'b0;
            r_data       <= 8'd0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_s    <= r_rx_meta;
            r_valid   <= 1'b0;
            if (!bus.rx_enable) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else if (r_state == IDLE) begin
                if (bus.os_tick && !r_rx_s) begin
                    r_state      <= START;
                    r_cnt        <= 4'd0;
                    r_cfg        <= bus.cfg_reg;
                    r_busy       <= 1'b1;
                    r_shift      <= 8'd0;
                    r_idx        <= 3'd0;
                    r_stop2      <= 1'b0;
                    r_par_flag   <= 1'b0;
                    r_frame_flag <= 1'b0;
                end
            end else if (bus.os_tick) begin
                r_cnt <= w_decide ? 4'd0 : r_cnt + 4'd1;
                if (w_decide) begin
                    case (r_state)
                        START: begin
                            r_state <= w_bit ? IDLE : DATA;
                            r_busy  <= !w_bit;
                        end
                        DATA: begin
                            r_shift[r_idx] <= w_bit;
                            r_idx          <= r_idx + 3'd1;
                            if (r_idx == w_len_m1) r_state <= r_cfg[3] ? PARITY : STOP;
                        end
                        PARITY: begin
                            if (w_bit != (^r_shift ^ r_cfg[4])) r_par_flag <= 1'b1;
                            r_state <= STOP;
                        end
                        STOP: begin
                            if (!w_bit) r_frame_flag <= 1'b1;
                            if (r_cfg[2] && !r_stop2) begin
                                r_stop2 <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_valid <= 1'b1;
                                r_data  <= r_shift;
                                r_perr  <= r_par_flag;
                                r_ferr  <= r_frame_flag | !w_bit;
                            end
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end
    assign bus.rx_data    = r_data;
    assign bus.rx_valid   = r_valid;
    assign bus.rx_busy    = r_busy;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames checked against a frame-level model of the receiver.
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst_n;
    uart_rx_if bus();
    uart_rx dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   vcnt = 0;
    int   long_cnt = 0;
    logic busy_at_valid = 1'b0;
    logic prev_valid = 1'b0;
    logic mid_busy;
    logic line_q[$];
    logic [7:0] exp_data;
    logic exp_perr, exp_ferr;
    logic [7:0] keep_data;
    logic keep_perr, keep_ferr;
    int   v0;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            vcnt++;
            busy_at_valid = bus.rx_busy;
        end
        if (bus.rx_valid && prev_valid) long_cnt++;
        prev_valid = bus.rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_period(input logic v);
        @(negedge clk);
        bus.rx = v;
        bus.os_tick = 1'b0;
        repeat (2) @(negedge clk);
        bus.os_tick = 1'b1;
        @(negedge clk);
        bus.os_tick = 1'b0;
    endtask

    // Line image of one frame plus the result the receiver should report for it.
    task automatic build(input logic [4:0] cfg, input logic [7:0] data, input logic par_ok, input logic [1:0] bad);
        int len, stops;
        logic p;
        len = int'(cfg[1:0]) + 5;
        stops = cfg[2] ? 2 : 1;
        bus.cfg_reg = cfg;
        exp_data = data & 8'((1 << len) - 1);
        line_q = {};
        line_q.push_back(1'b0);
        for (int k = 0; k < len; k++) line_q.push_back(data[k]);
        exp_perr = 1'b0;
        if (cfg[3]) begin
            p = ^exp_data ^ cfg[4];
            line_q.push_back(par_ok ? p : !p);
            exp_perr = !par_ok;
        end
        exp_ferr = 1'b0;
        for (int s = 0; s < stops; s++) begin
            line_q.push_back(!bad[s]);
            if (bad[s]) exp_ferr = 1'b1;
        end
    endtask

    // mode 0 = full frame, 1 = drop rx_enable at abs_tick, 2 = reset at abs_tick.
    // The last bit is driven only up to its decision tick so a 0 stop bit cannot look like a new start.
    task automatic send(input int mode, input int abs_tick, input int glitch_tick);
        int n, a;
        tick_period(1'b1);
        tick_period(1'b1);
        for (int i = 0; i < line_q.size(); i++) begin
            n = (i == line_q.size() - 1) ? 9 : 16;
            for (int t = 0; t < n; t++) begin
                a = i * 16 + t;
                if (a == 20) mid_busy = bus.rx_busy;
                if (mode != 0 && a == abs_tick) begin
                    if (mode == 1) begin
                        bus.rx_enable = 1'b0;
                        repeat (3) tick_period(1'b1);
                        bus.rx_enable = 1'b1;
                    end else begin
                        rst_n = 1'b0;
                        bus.rx = 1'b1;
                        @(negedge clk);
                    end
                    return;
                end
                tick_period(a == glitch_tick ? 1'b0 : line_q[i]);
            end
        end
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame(input string tag, input logic [4:0] cfg, input logic [7:0] data, input logic par_ok, input logic [1:0] bad);
        int v;
        v = vcnt;
        build(cfg, data, par_ok, bad);
        send(0, -1, -1);
        chk({tag, " valid"}, vcnt - v, 1);
        chk({tag, " data"}, bus.rx_data, exp_data);
        chk({tag, " perr"}, bus.parity_err, exp_perr);
        chk({tag, " ferr"}, bus.frame_err, exp_ferr);
        chk({tag, " busy_mid"}, mid_busy, 1);
        chk({tag, " busy_at_valid"}, busy_at_valid, 0);
        chk({tag, " busy_after"}, bus.rx_busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.rx = 1'b1;
        bus.rx_enable = 1'b1;
        bus.cfg_reg = 5'd0;
        bus.os_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst data", bus.rx_data, 0);
        chk("rst valid", bus.rx_valid, 0);
        chk("rst busy", bus.rx_busy, 0);
        chk("rst perr", bus.parity_err, 0);
        chk("rst ferr", bus.frame_err, 0);
        rst_n = 1'b1;

        frame("8N1 A5", 5'b00011, 8'hA5, 1'b1, 2'b00);
        frame("7E1 53", 5'b01010, 8'h53, 1'b1, 2'b00);
        frame("7E1 53 badpar", 5'b01010, 8'h53, 1'b0, 2'b00);
        frame("8O2 3C badstop2", 5'b11111, 8'h3C, 1'b1, 2'b10);
        frame("5N1 0F", 5'b00000, 8'h0F, 1'b1, 2'b00);

        v0 = vcnt;
        for (int t = 0; t < 4; t++) tick_period(1'b0);
        for (int t = 0; t < 12; t++) tick_period(1'b1);
        repeat (4) @(negedge clk);
        chk("glitch valid", vcnt - v0, 0);
        chk("glitch busy", bus.rx_busy, 0);
        chk("glitch data", bus.rx_data, 8'h0F);

        keep_data = bus.rx_data;
        keep_perr = bus.parity_err;
        keep_ferr = bus.frame_err;
        v0 = vcnt;
        build(5'b00011, 8'h77, 1'b1, 2'b00);
        send(1, 16 * 3 + 4, -1);
        repeat (4) @(negedge clk);
        chk("abort valid", vcnt - v0, 0);
        chk("abort busy", bus.rx_busy, 0);
        chk("abort data", bus.rx_data, keep_data);
        chk("abort perr", bus.parity_err, keep_perr);
        chk("abort ferr", bus.frame_err, keep_ferr);

        frame("pre-reset 3", 5'b01111, 8'hC3, 1'b0, 2'b01);
        build(5'b00011, 8'h99, 1'b1, 2'b00);
        send(2, 16 * 4 + 2, -1);
        chk("reset data", bus.rx_data, 0);
        chk("reset valid", bus.rx_valid, 0);
        chk("reset busy", bus.rx_busy, 0);
        chk("reset perr", bus.parity_err, 0);
        chk("reset ferr", bus.frame_err, 0);
        rst_n = 1'b1;
        frame("8N1 5A", 5'b00011, 8'h5A, 1'b1, 2'b00);

        // Glitch on data bit 1: cnt 14 under majority vote, decision tick otherwise.
        build(5'b00011, 8'hFF, 1'b1, 2'b00);
`ifdef UART_RX_MAJORITY_EN
        send(0, -1, 2 * 16 + 7);
        chk("glitch bit", bus.rx_data, 8'hFF);
`else
        send(0, -1, 2 * 16 + 8);
        chk("glitch bit", bus.rx_data, 8'hFD);
`endif

        for (int r = 0; r < 10; r++) begin
            logic [4:0] cfg;
            logic [7:0] data;
            logic par_ok;
            logic [1:0] bad;
            cfg = 5'($urandom_range(0, 31));
            data = 8'($urandom);
            par_ok = $urandom_range(0, 3) != 0;
            bad = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            frame($sformatf("rand%0d", r), cfg, data, par_ok, bad);
        end

        chk("valid one clk", long_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
